// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous input, measured in clk cycles.
// Reports one result per input cycle with a valid strobe and flags loss of signal.
module period_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e state_q, state_d;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise;
  logic at_max;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // s1/s2 form the metastability guard; s3 only delays s2 for edge detection.
  always_comb begin
    s1_d   = sig_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise   = s2_q & ~s3_q;
    at_max = (cnt_q == MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (rise) state_d = MEASURE;
        MEASURE: if (!rise && at_max) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The rise cycle itself counts as the first cycle of the next window,
  // so cnt restarts at 1 and period equals the exact rise-to-rise distance.
  always_comb begin
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    if (!enable) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d  = ONE;
            hcnt_d = ONE;
          end else begin
            cnt_d  = '0;
            hcnt_d = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hcnt_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = ONE;
            hcnt_d      = ONE;
          end else if (at_max) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_q + ONE;
            if (s2_q) hcnt_d = hcnt_q + ONE;
          end
        end
        default: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter at CNT_W=8; expected values are hand-derived.
module tb_period_meter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;
  int tstep    = 0;
  int nvalid   = 0;
  int last_v   = 0;
  int gap      = 0;
  int base     = 0;

  period_meter #(.CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, tstep);
    end
  endtask

  // One clk cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    tstep++;
    if (valid) begin
      nvalid++;
      gap    = tstep - last_v;
      last_v = tstep;
    end
  endtask

  task automatic steps(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = v;
      tick();
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      steps(1'b1, hi);
      steps(1'b0, lo);
    end
  endtask

  task automatic pulse_reset();
    sig_in = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    sig_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_period", period, 0);
    check_eq("rst_high", high_time, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_timeout", timeout, 0);

    // 19/19 square wave: first rise only arms, valids every 38 cycles after.
    pulse_reset();
    base = nvalid;
    wave(19, 19, 1);
    check_eq("sq_first_edge_no_valid", nvalid - base, 0);
    wave(19, 19, 3);
    check_eq("sq_valid_count", nvalid - base, 3);
    check_eq("sq_period", period, 38);
    check_eq("sq_high", high_time, 19);
    check_eq("sq_gap", gap, 38);
    check_eq("sq_timeout", timeout, 0);

    // 10 high / 30 low.
    pulse_reset();
    base = nvalid;
    wave(10, 30, 4);
    check_eq("pwm_valid_count", nvalid - base, 3);
    check_eq("pwm_period", period, 40);
    check_eq("pwm_high", high_time, 10);
    check_eq("pwm_gap", gap, 40);

    // Single rise then stuck low: timeout 255 cycles after the rise cycle.
    pulse_reset();
    base = nvalid;
    steps(1'b1, 5);
    steps(1'b0, 252);
    check_eq("to_not_yet", timeout, 0);
    steps(1'b0, 1);
    check_eq("to_asserted", timeout, 1);
    check_eq("to_no_valid", nvalid - base, 0);
    steps(1'b0, 20);
    check_eq("to_held", timeout, 1);
    wave(25, 25, 1);
    check_eq("to_rearm_no_valid", nvalid - base, 0);
    check_eq("to_held_after_first_edge", timeout, 1);
    steps(1'b1, 2);
    check_eq("to_valid_not_early", valid, 0);
    steps(1'b1, 1);
    check_eq("to_valid_pulse", valid, 1);
    check_eq("to_period50", period, 50);
    check_eq("to_high25", high_time, 25);
    check_eq("to_cleared", timeout, 0);
    steps(1'b1, 1);
    check_eq("to_valid_one_cycle", valid, 0);
    check_eq("to_valid_count", nvalid - base, 1);

    // Rises 255 apart: full-scale period, no timeout.
    pulse_reset();
    base = nvalid;
    steps(1'b1, 5);
    steps(1'b0, 250);
    steps(1'b1, 5);
    steps(1'b0, 250);
    check_eq("max_valid_count", nvalid - base, 1);
    check_eq("max_period", period, 255);
    check_eq("max_high", high_time, 5);
    check_eq("max_no_timeout", timeout, 0);
    // Next rise 256 after the previous one: timeout first, rise becomes a first edge.
    steps(1'b0, 1);
    steps(1'b1, 2);
    check_eq("over_timeout", timeout, 1);
    check_eq("over_period_held", period, 255);
    steps(1'b1, 3);
    check_eq("over_no_valid", nvalid - base, 1);
    check_eq("over_timeout_held", timeout, 1);
    steps(1'b0, 245);
    steps(1'b1, 3);
    check_eq("over_next_valid", valid, 1);
    check_eq("over_period250", period, 250);
    check_eq("over_high5", high_time, 5);
    check_eq("over_timeout_clr", timeout, 0);

    // Reset in the middle of a measurement.
    pulse_reset();
    base = nvalid;
    wave(19, 19, 3);
    check_eq("mid_pre_count", nvalid - base, 2);
    check_eq("mid_pre_period", period, 38);
    steps(1'b1, 19);
    steps(1'b0, 1);
    pulse_reset();
    check_eq("mid_rst_period", period, 0);
    check_eq("mid_rst_high", high_time, 0);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_timeout", timeout, 0);
    steps(1'b0, 17);
    base = nvalid;
    wave(19, 19, 1);
    check_eq("mid_first_edge_no_valid", nvalid - base, 0);
    steps(1'b1, 3);
    check_eq("mid_valid", valid, 1);
    check_eq("mid_period", period, 38);
    check_eq("mid_high", high_time, 19);

    // Enable dropped for 5 cycles mid-stream.
    pulse_reset();
    base = nvalid;
    wave(20, 20, 3);
    check_eq("en_pre_count", nvalid - base, 2);
    check_eq("en_pre_period", period, 40);
    check_eq("en_pre_high", high_time, 20);
    steps(1'b1, 10);
    check_eq("en_pre_count2", nvalid - base, 3);
    enable = 1'b0;
    steps(1'b1, 5);
    check_eq("en_off_no_valid", nvalid - base, 3);
    enable = 1'b1;
    steps(1'b0, 20);
    wave(19, 19, 1);
    check_eq("en_first_edge_no_valid", nvalid - base, 3);
    check_eq("en_period_held", period, 40);
    check_eq("en_high_held", high_time, 20);
    steps(1'b1, 3);
    check_eq("en_valid", valid, 1);
    check_eq("en_period", period, 38);
    check_eq("en_high", high_time, 19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
